// File: rtl/huffman_pkg.sv
// Shared types and width helpers for the canonical Huffman decoder.
// Imported by the code table, the decoder top and the bench.
package huffman_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } huff_state_e;

  typedef struct packed {
    logic [15:0] symbol;
    logic [7:0]  len;
    logic        err;
  } huff_beat_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int idx_w(input int num_sym);
    return $clog2(num_sym);
  endfunction

endpackage

// File: rtl/huffman_if.sv
// Bit-in / symbol-out valid-ready bundle of the Huffman decoder.
// master drives bits and consumes beats; slave is the decoder.
interface huffman_if #(
  parameter int SYM_W = 5,
  parameter int LEN_W = 4
);
  logic             bit_valid;
  logic             bit_in;
  logic             bit_ready;
  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] symbol_out;
  logic [LEN_W-1:0] len_out;
  logic             err_out;

  modport master (
    output bit_valid, bit_in, sym_ready,
    input  bit_ready, sym_valid,
    input  symbol_out, len_out, err_out
  );

  modport slave (
    input  bit_valid, bit_in, sym_ready,
    output bit_ready, sym_valid,
    output symbol_out, len_out, err_out
  );
endinterface

// File: rtl/huffman_code_table.sv
// Run-time loadable canonical table: code counts per length
// and the symbol list in canonical order. Writes gated by wr_en.
module huffman_code_table
  import huffman_pkg::*;
#(
  parameter int SYM_W   = 5,
  parameter int NUM_SYM = 32,
  parameter int MAX_LEN = 8,
  localparam int LEN_W  = len_w(MAX_LEN),
  localparam int IDX_W  = idx_w(NUM_SYM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             cnt_we,
  input  logic [LEN_W-1:0] cnt_len,
  input  logic [IDX_W:0]   cnt,
  input  logic             sym_we,
  input  logic [IDX_W-1:0] sym_idx,
  input  logic [SYM_W-1:0] sym,
  input  logic [LEN_W-1:0] rd_len,
  output logic [IDX_W:0]   rd_cnt,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [SYM_W-1:0] rd_sym
);

  logic [IDX_W:0]   cnt_q [MAX_LEN+1];
  logic [SYM_W-1:0] sym_q [NUM_SYM];

  logic cnt_ok;
  logic sym_ok;

  assign cnt_ok = (cnt_len != '0) &&
                  (cnt_len <= LEN_W'(MAX_LEN));
  assign sym_ok = 32'(sym_idx) < NUM_SYM;

  // table storage, cleared by reset, written only when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= MAX_LEN; i++) cnt_q[i] <= '0;
      for (int i = 0; i < NUM_SYM; i++) sym_q[i] <= '0;
    end else begin
      if (wr_en && cnt_we && cnt_ok) cnt_q[cnt_len] <= cnt;
      if (wr_en && sym_we && sym_ok) sym_q[sym_idx] <= sym;
    end
  end

  assign rd_cnt = (rd_len <= LEN_W'(MAX_LEN)) ?
                  cnt_q[rd_len] : '0;
  assign rd_sym = (32'(rd_idx) < NUM_SYM) ?
                  sym_q[rd_idx] : '0;

endmodule

// File: rtl/huffman_decoder_canon.sv
// Canonical-Huffman bit-serial decoder, loadable table.
// Optional statistics counters: define HUFF_DEC_STATS_EN.
module huffman_decoder_canon
  import huffman_pkg::*;
#(
  parameter int SYM_W   = 5,
  parameter int NUM_SYM = 32,
  parameter int MAX_LEN = 8,
  localparam int LEN_W  = len_w(MAX_LEN),
  localparam int IDX_W  = idx_w(NUM_SYM)
) (
  input  logic             clk,
  input  logic             rst_n,
  huffman_if.slave         bus,
  input  logic             cfg_cnt_we,
  input  logic [LEN_W-1:0] cfg_cnt_len,
  input  logic [IDX_W:0]   cfg_cnt,
  input  logic             cfg_sym_we,
  input  logic [IDX_W-1:0] cfg_sym_idx,
  input  logic [SYM_W-1:0] cfg_sym,
  output logic [31:0]      stat_sym_cnt,
  output logic [31:0]      stat_err_cnt
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_ACC  = 2'(ACC);
  localparam logic [1:0] S_HOLD = 2'(HOLD);

  localparam int W  = MAX_LEN + 1;
  localparam int AW = MAX_LEN + IDX_W + 2;

  logic [1:0]       state;
  logic [W-1:0]     code;
  logic [W-1:0]     first;
  logic [IDX_W:0]   index;
  logic [LEN_W-1:0] len;

  logic [SYM_W-1:0] sym_q;
  logic [LEN_W-1:0] len_q;
  logic             err_q;

  logic [IDX_W:0]   n;
  logic [SYM_W-1:0] sym_rd;
  logic [W-1:0]     c;
  logic [AW-1:0]    c_w, f_w, n_w;
  logic [AW-1:0]    diff, sidx, fn;
  logic             hit, last, take, done;

  assign bus.bit_ready  = rst_n && (state != S_HOLD);
  assign bus.sym_valid  = (state == S_HOLD);
  assign bus.symbol_out = sym_q;
  assign bus.len_out    = len_q;
  assign bus.err_out    = err_q;

  assign take = bus.bit_valid && bus.bit_ready;
  assign done = (state == S_HOLD) && bus.sym_ready;

  assign c    = {code[W-2:0], bus.bit_in};
  assign c_w  = AW'(c);
  assign f_w  = AW'(first);
  assign n_w  = AW'(n);
  assign diff = c_w - f_w;
  assign sidx = AW'(index) + diff;
  assign fn   = (f_w + n_w) << 1;
  assign last = (len == LEN_W'(MAX_LEN));
  assign hit  = (c_w >= f_w) && (diff < n_w) &&
                (sidx < AW'(NUM_SYM));

  huffman_code_table #(
    .SYM_W  (SYM_W),
    .NUM_SYM(NUM_SYM),
    .MAX_LEN(MAX_LEN)
  ) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (state == S_IDLE),
    .cnt_we (cfg_cnt_we),
    .cnt_len(cfg_cnt_len),
    .cnt    (cfg_cnt),
    .sym_we (cfg_sym_we),
    .sym_idx(cfg_sym_idx),
    .sym    (cfg_sym),
    .rd_len (len),
    .rd_cnt (n),
    .rd_idx (sidx[IDX_W-1:0]),
    .rd_sym (sym_rd)
  );

  // decode FSM: grow the code one bit at a time, hold the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      code  <= '0;
      first <= '0;
      index <= '0;
      len   <= LEN_W'(1);
      sym_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (1'b1)
        done: begin
          state <= S_IDLE;
          code  <= '0;
          first <= '0;
          index <= '0;
          len   <= LEN_W'(1);
        end
        take && hit: begin
          state <= S_HOLD;
          sym_q <= sym_rd;
          len_q <= len;
          err_q <= 1'b0;
        end
        take && !hit && last: begin
          state <= S_HOLD;
          sym_q <= '0;
          len_q <= LEN_W'(MAX_LEN);
          err_q <= 1'b1;
        end
        take && !hit && !last: begin
          state <= S_ACC;
          index <= index + n;
          first <= fn[W-1:0];
          code  <= c;
          len   <= len + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef HUFF_DEC_STATS_EN
  logic [31:0] sym_cnt_q;
  logic [31:0] err_cnt_q;

  // count completed beats by outcome
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (done) begin
      if (err_q) err_cnt_q <= err_cnt_q + 32'd1;
      else       sym_cnt_q <= sym_cnt_q + 32'd1;
    end
  end

  assign stat_sym_cnt = sym_cnt_q;
  assign stat_err_cnt = err_cnt_q;
`else
  assign stat_sym_cnt = 32'd0;
  assign stat_err_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_huffman_decoder_canon.sv
// Bench for huffman_decoder_canon: directed steps plus random
// tables checked against a code-list reference model.
module tb_huffman_decoder_canon;
  import huffman_pkg::*;

  localparam int SYM_W   = 5;
  localparam int NUM_SYM = 32;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = len_w(MAX_LEN);
  localparam int IDX_W   = idx_w(NUM_SYM);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic             cfg_cnt_we = 1'b0;
  logic [LEN_W-1:0] cfg_cnt_len = '0;
  logic [IDX_W:0]   cfg_cnt = '0;
  logic             cfg_sym_we = 1'b0;
  logic [IDX_W-1:0] cfg_sym_idx = '0;
  logic [SYM_W-1:0] cfg_sym = '0;
  logic [31:0]      stat_sym_cnt;
  logic [31:0]      stat_err_cnt;

  huffman_if #(.SYM_W(SYM_W), .LEN_W(LEN_W)) bus();

  huffman_decoder_canon #(
    .SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cfg_cnt_we  (cfg_cnt_we),
    .cfg_cnt_len (cfg_cnt_len),
    .cfg_cnt     (cfg_cnt),
    .cfg_sym_we  (cfg_sym_we),
    .cfg_sym_idx (cfg_sym_idx),
    .cfg_sym     (cfg_sym),
    .stat_sym_cnt(stat_sym_cnt),
    .stat_err_cnt(stat_err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int good_n = 0;
  int bad_n  = 0;

  int m_cnt [MAX_LEN+1];
  int m_sym [NUM_SYM];
  int ent_len[$];
  int ent_code[$];
  int ent_sym[$];
  int mv = 0;
  int ml = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h",
               tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cfg_write(input bit cw, input int cl,
                           input int cv, input bit sw,
                           input int si, input int sv);
    @(negedge clk);
    cfg_cnt_we  = cw;
    cfg_cnt_len = LEN_W'(cl);
    cfg_cnt     = (IDX_W+1)'(cv);
    cfg_sym_we  = sw;
    cfg_sym_idx = IDX_W'(si);
    cfg_sym     = SYM_W'(sv);
    @(posedge clk);
    #1;
    cfg_cnt_we = 1'b0;
    cfg_sym_we = 1'b0;
  endtask

  // load m_cnt/m_sym; build the canonical code list
  task automatic load_table();
    int code;
    for (int i = 0; i < NUM_SYM; i++)
      cfg_write(i >= 1 && i <= MAX_LEN, i,
                (i <= MAX_LEN) ? m_cnt[i] : 0,
                1'b1, i, m_sym[i]);
    ent_len.delete();
    ent_code.delete();
    ent_sym.delete();
    code = 0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      for (int j = 0; j < m_cnt[l]; j++) begin
        ent_sym.push_back(m_sym[ent_len.size()]);
        ent_len.push_back(l);
        ent_code.push_back(code);
        code++;
      end
      code = code * 2;
    end
    mv = 0;
    ml = 0;
  endtask

  task automatic basic_table(input int l3);
    for (int i = 0; i <= MAX_LEN; i++) m_cnt[i] = 0;
    for (int i = 0; i < NUM_SYM; i++) m_sym[i] = 0;
    m_cnt[1] = 1;
    m_cnt[2] = 1;
    m_cnt[3] = l3;
    for (int i = 0; i < 4; i++) m_sym[i] = i + 1;
    load_table();
  endtask

  task automatic send_bit(input logic b);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.bit_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("bit_ready_timeout", bus.bit_ready, 1);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input int s,
                             input int l, input int e,
                             input int stall);
    chk({tag, "_valid"}, bus.sym_valid, 1);
    chk({tag, "_sym"}, bus.symbol_out, s);
    chk({tag, "_len"}, bus.len_out, l);
    chk({tag, "_err"}, bus.err_out, e);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold_rdy"}, bus.bit_ready, 0);
      chk({tag, "_hold_v"}, bus.sym_valid, 1);
      chk({tag, "_hold_sym"},
          {bus.symbol_out, bus.len_out, bus.err_out},
          {SYM_W'(s), LEN_W'(l), 1'(e)});
    end
    @(negedge clk);
    bus.sym_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.sym_ready = 1'b0;
    chk({tag, "_done_v"}, bus.sym_valid, 0);
    chk({tag, "_done_rdy"}, bus.bit_ready, 1);
    if (e != 0) bad_n++;
    else good_n++;
  endtask

  task automatic model_bit(input int b, output bit fire,
                           output huff_beat_t bt);
    fire = 1'b0;
    bt   = '0;
    mv = mv * 2 + b;
    ml++;
    for (int k = 0; k < ent_len.size(); k++)
      if (ent_len[k] == ml && ent_code[k] == mv) begin
        fire = 1'b1;
        bt.symbol = 16'(ent_sym[k]);
        bt.len    = 8'(ml);
      end
    if (!fire && ml == MAX_LEN) begin
      fire   = 1'b1;
      bt.len = 8'(MAX_LEN);
      bt.err = 1'b1;
    end
    if (fire) begin
      mv = 0;
      ml = 0;
    end
  endtask

  task automatic feed(input int b);
    bit fire;
    huff_beat_t bt;
    model_bit(b, fire, bt);
    send_bit(1'(b));
    if (fire)
      expect_beat("rnd", int'(bt.symbol), int'(bt.len),
                  int'(bt.err), $urandom_range(0, 2));
    else
      chk("rnd_busy", bus.sym_valid, 0);
  endtask

  task automatic rand_table();
    int budget, unit, mx, k;
    budget = 1 << MAX_LEN;
    k = 0;
    m_cnt[0] = 0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      unit = 1 << (MAX_LEN - l);
      mx = budget / unit;
      if (mx > NUM_SYM - k) mx = NUM_SYM - k;
      if (mx > 6) mx = 6;
      m_cnt[l] = int'($urandom_range(0, mx));
      budget -= m_cnt[l] * unit;
      k += m_cnt[l];
    end
    for (int i = 0; i < NUM_SYM; i++)
      m_sym[i] = int'($urandom_range(0, 31));
    load_table();
  endtask

  task automatic chk_stats(input string tag);
`ifdef HUFF_DEC_STATS_EN
    chk({tag, "_sym_cnt"}, stat_sym_cnt, good_n);
    chk({tag, "_err_cnt"}, stat_err_cnt, bad_n);
`else
    chk({tag, "_sym_cnt"}, stat_sym_cnt, 0);
    chk({tag, "_err_cnt"}, stat_err_cnt, 0);
`endif
  endtask

  initial begin
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.sym_ready = 1'b0;
    #12;
    chk("rst_bit_ready", bus.bit_ready, 0);
    chk("rst_sym_valid", bus.sym_valid, 0);
    chk("rst_symbol", bus.symbol_out, 0);
    chk("rst_len", bus.len_out, 0);
    chk("rst_err", bus.err_out, 0);
    chk_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", bus.bit_ready, 1);

    for (int i = 0; i < MAX_LEN - 1; i++) begin
      send_bit(1'b0);
      chk("empty_busy", bus.sym_valid, 0);
    end
    send_bit(1'b0);
    expect_beat("empty", 0, MAX_LEN, 1, 0);

    basic_table(2);
    send_bit(1'b0);
    expect_beat("c0", 1, 1, 0, 0);
    send_bit(1'b1); send_bit(1'b0);
    expect_beat("c10", 2, 2, 0, 0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    expect_beat("c110", 3, 3, 0, 0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    expect_beat("c111", 4, 3, 0, 0);

    basic_table(1);
    for (int i = 0; i < MAX_LEN - 1; i++) begin
      send_bit(1'b1);
      chk("miss_busy", bus.sym_valid, 0);
    end
    send_bit(1'b1);
    expect_beat("miss", 0, MAX_LEN, 1, 0);

    basic_table(2);
    send_bit(1'b0);
    expect_beat("hold", 1, 1, 0, 5);
    send_bit(1'b0);
    expect_beat("after_hold", 1, 1, 0, 0);

    send_bit(1'b1); send_bit(1'b1);
    cfg_write(1'b1, 3, 0, 1'b1, 2, 7);
    send_bit(1'b0);
    expect_beat("midcfg", 3, 3, 0, 0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    expect_beat("midcfg_again", 3, 3, 0, 0);
    chk_stats("pre_rst");

    send_bit(1'b1); send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.sym_valid, 0);
    chk("arst_ready", bus.bit_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    good_n = 0;
    bad_n  = 0;
    chk_stats("arst");
    for (int i = 0; i <= MAX_LEN; i++) m_cnt[i] = 0;
    for (int i = 0; i < NUM_SYM; i++) m_sym[i] = 0;
    m_cnt[1] = 1;
    m_sym[0] = 1;
    load_table();
    send_bit(1'b0);
    expect_beat("reload", 1, 1, 0, 0);

    for (int r = 0; r < 4; r++) begin
      rand_table();
      for (int i = 0; i < 150; i++)
        feed(int'($urandom_range(0, 1)));
      while (ml != 0) feed(int'($urandom_range(0, 1)));
    end
    chk_stats("final");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
